// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing control for the 5-stage core.
// Tracks EX/MEM/WB destinations and drives the PC, IF/ID and ID/EX enables
// and flushes, plus EX operand-forwarding selects.
// Optional macro PIPELINE_FORWARDING_EN: enables forwarding, so only load-use
// stalls; without it, any in-flight RAW stalls and forwarding is tied to 00.
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd_addr,
  input  logic       id_writes_rd,
  input  logic       id_is_load,
  input  logic       ex_redirect,
  input  logic       mem_stall_req,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       hazard_stall
);

  typedef enum logic [1:0] {MODE_RUN, MODE_STALL, MODE_REDIRECT, MODE_FREEZE} mode_e;

  logic       ex_valid_q, ex_valid_d, ex_wr_q, ex_wr_d, ex_load_q, ex_load_d;
  logic [4:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic       ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
  logic       mem_valid_q, mem_valid_d, mem_wr_q, mem_wr_d, mem_load_q, mem_load_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       wb_valid_q, wb_valid_d, wb_wr_q, wb_wr_d;
  logic [4:0] wb_rd_q, wb_rd_d;

  logic       ex_hz, mem_hz, wb_hz, raw_hit;
  mode_e      mode;

  function automatic logic src_hit(input logic slot_hz, input logic [4:0] slot_rd,
                                   input logic uses, input logic [4:0] src);
    return slot_hz & uses & (slot_rd == src);
  endfunction

  // Slot qualification (x0 and bubbles never hazard) and per-cycle priority
  always_comb begin
    ex_hz  = ex_valid_q  & ex_wr_q  & (ex_rd_q  != '0);
    mem_hz = mem_valid_q & mem_wr_q & (mem_rd_q != '0);
    wb_hz  = wb_valid_q  & wb_wr_q  & (wb_rd_q  != '0);
`ifdef PIPELINE_FORWARDING_EN
    raw_hit = ex_load_q & (src_hit(ex_hz, ex_rd_q, id_uses_rs1, id_rs1_addr) |
                           src_hit(ex_hz, ex_rd_q, id_uses_rs2, id_rs2_addr));
`else
    // Regfile has no write-through, so WB still blocks an ID read
    raw_hit = src_hit(ex_hz,  ex_rd_q,  id_uses_rs1, id_rs1_addr) |
              src_hit(ex_hz,  ex_rd_q,  id_uses_rs2, id_rs2_addr) |
              src_hit(mem_hz, mem_rd_q, id_uses_rs1, id_rs1_addr) |
              src_hit(mem_hz, mem_rd_q, id_uses_rs2, id_rs2_addr) |
              src_hit(wb_hz,  wb_rd_q,  id_uses_rs1, id_rs1_addr) |
              src_hit(wb_hz,  wb_rd_q,  id_uses_rs2, id_rs2_addr);
`endif
    if (mem_stall_req)          mode = MODE_FREEZE;
    else if (ex_redirect)       mode = MODE_REDIRECT;
    else if (id_valid && raw_hit) mode = MODE_STALL;
    else                        mode = MODE_RUN;
  end

  // Tracker next state: hold on freeze, otherwise shift; EX takes ID only in RUN
  always_comb begin
    wb_valid_d  = mem_valid_q;
    wb_wr_d     = mem_wr_q;
    wb_rd_d     = mem_rd_q;
    mem_valid_d = ex_valid_q;
    mem_wr_d    = ex_wr_q;
    mem_rd_d    = ex_rd_q;
    mem_load_d  = ex_load_q;
    ex_valid_d  = 1'b0;
    ex_wr_d     = 1'b0;
    ex_rd_d     = '0;
    ex_load_d   = 1'b0;
    ex_rs1_d    = '0;
    ex_rs2_d    = '0;
    ex_use1_d   = 1'b0;
    ex_use2_d   = 1'b0;
    case (mode)
      MODE_FREEZE: begin
        wb_valid_d  = wb_valid_q;
        wb_wr_d     = wb_wr_q;
        wb_rd_d     = wb_rd_q;
        mem_valid_d = mem_valid_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        mem_load_d  = mem_load_q;
        ex_valid_d  = ex_valid_q;
        ex_wr_d     = ex_wr_q;
        ex_rd_d     = ex_rd_q;
        ex_load_d   = ex_load_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_use1_d   = ex_use1_q;
        ex_use2_d   = ex_use2_q;
      end
      MODE_RUN: begin
        ex_valid_d = id_valid;
        ex_wr_d    = id_writes_rd;
        ex_rd_d    = id_rd_addr;
        ex_load_d  = id_is_load;
        ex_rs1_d   = id_rs1_addr;
        ex_rs2_d   = id_rs2_addr;
        ex_use1_d  = id_uses_rs1;
        ex_use2_d  = id_uses_rs2;
      end
      default: ;
    endcase
  end

  // Tracker registers; reset only needs to clear the valid bits
  always_ff @(posedge clk) begin
    ex_wr_q    <= ex_wr_d;
    ex_rd_q    <= ex_rd_d;
    ex_load_q  <= ex_load_d;
    ex_rs1_q   <= ex_rs1_d;
    ex_rs2_q   <= ex_rs2_d;
    ex_use1_q  <= ex_use1_d;
    ex_use2_q  <= ex_use2_d;
    mem_wr_q   <= mem_wr_d;
    mem_rd_q   <= mem_rd_d;
    mem_load_q <= mem_load_d;
    wb_wr_q    <= wb_wr_d;
    wb_rd_q    <= wb_rd_d;
    if (rst) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

`ifndef PIPELINE_FORWARDING_EN
  logic unused_fwd_state;
  assign unused_fwd_state = ^{ex_load_q, ex_rs1_q, ex_rs2_q, ex_use1_q, ex_use2_q, mem_load_q};
`endif

  // Pipeline controls and forwarding selects; reset overrides everything
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    hazard_stall = 1'b0;
    case (mode)
      MODE_FREEZE: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
      end
      MODE_REDIRECT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      MODE_STALL: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_flush  = 1'b1;
        hazard_stall = 1'b1;
      end
      default: ;
    endcase
    fwd_rs1_sel = 2'b00;
    fwd_rs2_sel = 2'b00;
`ifdef PIPELINE_FORWARDING_EN
    // Load data is not yet available in MEM, so only WB may forward a load
    if (ex_valid_q && src_hit(mem_hz & ~mem_load_q, mem_rd_q, ex_use1_q, ex_rs1_q))
      fwd_rs1_sel = 2'b01;
    else if (ex_valid_q && src_hit(wb_hz, wb_rd_q, ex_use1_q, ex_rs1_q))
      fwd_rs1_sel = 2'b10;
    if (ex_valid_q && src_hit(mem_hz & ~mem_load_q, mem_rd_q, ex_use2_q, ex_rs2_q))
      fwd_rs2_sel = 2'b01;
    else if (ex_valid_q && src_hit(wb_hz, wb_rd_q, ex_use2_q, ex_rs2_q))
      fwd_rs2_sel = 2'b10;
`endif
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b1;
      hazard_stall = 1'b0;
      fwd_rs1_sel  = 2'b00;
      fwd_rs2_sel  = 2'b00;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl.
// Expected control vectors are hand-computed for the configuration selected
// by PIPELINE_FORWARDING_EN.
module tb_pipeline_hazard_ctrl;

  logic       clk, rst, id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load;
  logic       ex_redirect, mem_stall_req;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, hazard_stall;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_addr(id_rd_addr), .id_writes_rd(id_writes_rd), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_stall_req(mem_stall_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .hazard_stall(hazard_stall)
  );

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, hazard_stall, fwd_rs1, fwd_rs2}
  localparam logic [9:0] E_RUN    = 10'b110100_00_00;
  localparam logic [9:0] E_STL    = 10'b000111_00_00;
  localparam logic [9:0] E_RED    = 10'b111110_00_00;
  localparam logic [9:0] E_FRZ    = 10'b000000_00_00;
  localparam logic [9:0] E_RST    = 10'b001110_00_00;
  localparam logic [9:0] E_RUN_10 = 10'b110100_10_00;
  localparam logic [9:0] E_RUN_11 = 10'b110100_01_01;
  localparam logic [9:0] E_RUN_01 = 10'b110100_01_00;

  typedef struct {
    logic [9:0] exp;
    string      name;
  } sb_ent_t;

  sb_ent_t sb_q[$];
  sb_ent_t ent;
  int      n_cmp = 0;
  int      n_bad = 0;
  logic [9:0] got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are presented every cycle; compare one entry per cycle
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      ent = sb_q.pop_front();
      got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, hazard_stall,
             fwd_rs1_sel, fwd_rs2_sel};
      n_cmp++;
      if (got !== ent.exp) begin
        n_bad++;
        $display("FAIL %s: got %b, expected %b", ent.name, got, ent.exp);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2, input logic [4:0] d, input logic w,
                      input logic l, input logic rdir, input logic ms,
                      input logic [9:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs1_addr = s1; id_rs2_addr = s2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd_addr = d; id_writes_rd = w;
    id_is_load = l; ex_redirect = rdir; mem_stall_req = ms;
    sb_q.push_back('{exp: e, name: nm});
  endtask

  task automatic idle(input logic [9:0] e, input string nm);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) idle(E_RUN, "drain");
  endtask

  // lw x5, 0(x2)
  task automatic lw5(input logic [9:0] e, input string nm);
    step(1'b0, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, e, nm);
  endtask

  // add x6, x5, x1
  task automatic add6(input logic r, input logic rdir, input logic ms,
                      input logic [9:0] e, input string nm);
    step(r, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, rdir, ms, e, nm);
  endtask

  // Non-load ALU op writing rd
  task automatic alu(input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                     input logic [4:0] d, input logic [9:0] e, input string nm);
    step(1'b0, 1'b1, s1, s2, 1'b1, u2, d, 1'b1, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd_addr = '0; id_writes_rd = 1'b0;
    id_is_load = 1'b0; ex_redirect = 1'b0; mem_stall_req = 1'b0;

    // Reset held two cycles, then released idle
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "reset_0");
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "reset_1");
    idle(E_RUN, "post_reset");
    drain();

    // Load-use: lw x5 ; add x6,x5,x1
    lw5(E_RUN, "lu_lw");
`ifdef PIPELINE_FORWARDING_EN
    add6(1'b0, 1'b0, 1'b0, E_STL, "lu_stall");
    add6(1'b0, 1'b0, 1'b0, E_RUN, "lu_issue");
    idle(E_RUN_10, "lu_fwd_wb");
`else
    for (int i = 0; i < 3; i++) add6(1'b0, 1'b0, 1'b0, E_STL, "lu_stall");
    add6(1'b0, 1'b0, 1'b0, E_RUN, "lu_issue");
    idle(E_RUN, "lu_no_fwd");
`endif
    drain();

    // ALU chain: addi x3,x1 ; sub x4,x3,x3
    alu(5'd1, 5'd0, 1'b0, 5'd3, E_RUN, "chain_addi");
`ifdef PIPELINE_FORWARDING_EN
    alu(5'd3, 5'd3, 1'b1, 5'd4, E_RUN, "chain_sub");
    idle(E_RUN_11, "chain_fwd_mem");
`else
    for (int i = 0; i < 3; i++) alu(5'd3, 5'd3, 1'b1, 5'd4, E_STL, "chain_stall");
    alu(5'd3, 5'd3, 1'b1, 5'd4, E_RUN, "chain_sub");
    idle(E_RUN, "chain_no_fwd");
`endif
    drain();

    // MEM-over-WB priority: addi x3,x1 ; addi x3,x2 ; add x4,x3,x0
    alu(5'd1, 5'd0, 1'b0, 5'd3, E_RUN, "prio_addi_a");
    alu(5'd2, 5'd0, 1'b0, 5'd3, E_RUN, "prio_addi_b");
`ifdef PIPELINE_FORWARDING_EN
    alu(5'd3, 5'd0, 1'b1, 5'd4, E_RUN, "prio_add");
    idle(E_RUN_01, "prio_fwd_mem");
`else
    for (int i = 0; i < 3; i++) alu(5'd3, 5'd0, 1'b1, 5'd4, E_STL, "raw3_stall");
    alu(5'd3, 5'd0, 1'b1, 5'd4, E_RUN, "raw3_issue");
`endif
    drain();

    // x0 immunity: addi x0,x1 ; add x7,x0,x0
    alu(5'd1, 5'd0, 1'b0, 5'd0, E_RUN, "x0_addi");
    alu(5'd0, 5'd0, 1'b1, 5'd7, E_RUN, "x0_add");
    idle(E_RUN, "x0_no_fwd");
    drain();

    // Redirect beats load-use stall
    lw5(E_RUN, "rvs_lw");
    add6(1'b0, 1'b1, 1'b0, E_RED, "rvs_redirect");
    idle(E_RUN, "rvs_after");
    drain();

    // Freeze beats redirect; redirect lands on the 4th cycle
    lw5(E_RUN, "frz_lw");
    for (int i = 0; i < 3; i++) add6(1'b0, 1'b1, 1'b1, E_FRZ, "frz_hold");
    add6(1'b0, 1'b1, 1'b0, E_RED, "frz_redirect");
    idle(E_RUN, "frz_after");
    drain();

    // Freeze keeps the tracker: pending load-use still stalls afterwards
    lw5(E_RUN, "frzt_lw");
    for (int i = 0; i < 3; i++) add6(1'b0, 1'b0, 1'b1, E_FRZ, "frzt_hold");
`ifdef PIPELINE_FORWARDING_EN
    add6(1'b0, 1'b0, 1'b0, E_STL, "frzt_stall");
    add6(1'b0, 1'b0, 1'b0, E_RUN, "frzt_issue");
    idle(E_RUN_10, "frzt_fwd_wb");
`else
    for (int i = 0; i < 3; i++) add6(1'b0, 1'b0, 1'b0, E_STL, "frzt_stall");
    add6(1'b0, 1'b0, 1'b0, E_RUN, "frzt_issue");
`endif
    drain();

    // Mid-operation reset discards the in-flight load
    lw5(E_RUN, "mrst_lw");
    add6(1'b1, 1'b0, 1'b0, E_RST, "mrst_reset");
    add6(1'b0, 1'b0, 1'b0, E_RUN, "mrst_issue");
    drain();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
